// File: rtl/chroma_upsample_mcu_pkg.sv
// Shared definitions for the MCU chroma upsampler.
//   CH            : number of channels per MCU (Y, Cb, Cr); `CH is the macro form
//   chroma_mode_t : runtime subsampling mode encoding (3 = reserved, acts as 4:4:4)
//   block_t       : 8x8 block of signed samples at the default sample width
//   ny_for_mode() : Y blocks per MCU for a given mode
`ifndef CH
`define CH 3
`endif

package chroma_upsample_mcu_pkg;

    localparam int CH         = `CH;
    localparam int PKG_DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_444 = 2'd0,
        MODE_422 = 2'd1,
        MODE_420 = 2'd2
    } chroma_mode_t;

    typedef logic signed [7:0][7:0][PKG_DATA_W-1:0] block_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    function automatic logic [2:0] ny_for_mode(input logic [1:0] m);
        case (m)
            2'(MODE_422): return 3'd2;
            2'(MODE_420): return 3'd4;
            default:      return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/chroma_upsample_mcu_replicate.sv
// Combinational chroma replication for one output block.
//   blk_i  : stored 8x8 chroma block
//   mode_i : subsampling mode (reserved value behaves as 4:4:4)
//   k_i    : index of the Y block being paired; k[0]=horizontal, k[1]=vertical half
//   blk_o  : 8x8 chroma block aligned to Y block k
module chroma_replicate
    import chroma_upsample_mcu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic signed [7:0][7:0][DATA_W-1:0] blk_i,
    input  logic        [1:0]                  mode_i,
    input  logic        [1:0]                  k_i,
    output logic signed [7:0][7:0][DATA_W-1:0] blk_o
);

    always_comb begin
        blk_o = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin : pix
                logic [2:0] rr, cc, sr, sc;
                rr = 3'(r);
                cc = 3'(c);
                sr = rr;
                sc = cc;
                // Half-resolution source: {half select, pixel/2} == 4*k + pixel/2
                if (mode_i == 2'(MODE_422)) begin
                    sc = {k_i[0], cc[2:1]};
                end else if (mode_i == 2'(MODE_420)) begin
                    sr = {k_i[1], rr[2:1]};
                    sc = {k_i[0], cc[2:1]};
                end
                blk_o[rr][cc] = blk_i[sr][sc];
            end
        end
    end

endmodule

// File: rtl/chroma_upsample_mcu.sv
// MCU chroma upsampler: buffers NY Y blocks plus one Cb and one Cr block,
// then emits one {Y, Cb, Cr} triplet per Y block with chroma replicated.
//   clk, rst_n            : clock, asynchronous active-low reset
//   mode                  : subsampling mode, latched on the first Y block
//   in_valid/in_ready     : input block handshake; in_ch tags Y/Cb/Cr
//   in_block              : input 8x8 block
//   out_valid/out_ready   : output triplet handshake
//   y/cb/cr_block_out     : aligned output blocks; out_idx = Y block index k
//   seq_err               : one-cycle pulse when an input block is dropped
//
// state      | meaning
// COLLECT    | accepting NY Y blocks, then Cb, then Cr
// EMIT       | presenting triplets k = 0..NY-1, input stalled
`ifndef CH
`define CH 3
`endif

module chroma_upsample_mcu
    import chroma_upsample_mcu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_Y  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic        [1:0]                   mode,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic        [$clog2(`CH+1)-1:0]     in_ch,
    input  logic signed [7:0][7:0][DATA_W-1:0]  in_block,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [7:0][7:0][DATA_W-1:0]  y_block_out,
    output logic signed [7:0][7:0][DATA_W-1:0]  cb_block_out,
    output logic signed [7:0][7:0][DATA_W-1:0]  cr_block_out,
    output logic        [1:0]                   out_idx,
    output logic                                seq_err
);

    localparam int YW = $clog2(MAX_Y + 1);
    localparam int IW = $clog2(MAX_Y);

    typedef logic signed [7:0][7:0][DATA_W-1:0] blk_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [YW-1:0]   y_cnt_q, y_cnt_d;
    logic            cb_got_q, cb_got_d;
    logic [1:0]      k_q, k_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            seq_err_q, seq_err_d;

    blk_t            ybuf_q [MAX_Y];
    blk_t            cbuf_q, crbuf_q;
    blk_t            y_out_q, cb_out_q, cr_out_q;
    blk_t            cb_up, cr_up, cr_src;

    logic [YW-1:0]   ny;
    logic            accept, y_ok, cb_ok, cr_ok;
    logic            wr_y, wr_cb, wr_cr, reject;
    logic            out_hs, k_last, load_out;
    logic [1:0]      k_load;

    assign ny     = YW'(ny_for_mode(mode_q));
    assign accept = in_valid && in_ready_q && (state_q == ST_COLLECT);
    // While y_cnt is 0, mode_q may be stale, but every mode allows at least one Y.
    assign y_ok   = (in_ch == 2'd0) && !cb_got_q && (y_cnt_q < ny);
    assign cb_ok  = (in_ch == 2'd1) && !cb_got_q && (y_cnt_q == ny);
    assign cr_ok  = (in_ch == 2'd2) && cb_got_q;
    assign wr_y   = accept && y_ok;
    assign wr_cb  = accept && cb_ok;
    assign wr_cr  = accept && cr_ok;
    assign reject = accept && !(y_ok || cb_ok || cr_ok);

    assign out_hs   = (state_q == ST_EMIT) && out_valid_q && out_ready;
    assign k_last   = (YW'(k_q) + YW'(1)) == ny;
    assign load_out = wr_cr || (out_hs && !k_last);
    assign k_load   = (state_q == ST_COLLECT) ? 2'd0 : k_q + 2'd1;

    // The Cr block is still on the input bus when the first triplet loads.
    assign cr_src = (state_q == ST_COLLECT) ? in_block : crbuf_q;

    chroma_replicate #(.DATA_W(DATA_W)) u_rep_cb (
        .blk_i  (cbuf_q),
        .mode_i (mode_q),
        .k_i    (k_load),
        .blk_o  (cb_up)
    );

    chroma_replicate #(.DATA_W(DATA_W)) u_rep_cr (
        .blk_i  (cr_src),
        .mode_i (mode_q),
        .k_i    (k_load),
        .blk_o  (cr_up)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        y_cnt_d     = y_cnt_q;
        cb_got_d    = cb_got_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        seq_err_d   = reject;
        case (state_q)
            ST_COLLECT: begin
                if (wr_y) begin
                    y_cnt_d = y_cnt_q + YW'(1);
                    if (y_cnt_q == '0) mode_d = mode;
                end
                if (wr_cb) cb_got_d = 1'b1;
                if (wr_cr) begin
                    state_d     = ST_EMIT;
                    k_d         = 2'd0;
                    out_valid_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_hs) begin
                    if (k_last) begin
                        state_d     = ST_COLLECT;
                        out_valid_d = 1'b0;
                        y_cnt_d     = '0;
                        cb_got_d    = 1'b0;
                        k_d         = 2'd0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        in_ready_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            mode_q      <= 2'd0;
            y_cnt_q     <= '0;
            cb_got_q    <= 1'b0;
            k_q         <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            y_cnt_q     <= y_cnt_d;
            cb_got_q    <= cb_got_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            seq_err_q   <= seq_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_Y; i++) ybuf_q[i] <= '0;
            cbuf_q   <= '0;
            crbuf_q  <= '0;
            y_out_q  <= '0;
            cb_out_q <= '0;
            cr_out_q <= '0;
        end else begin
            if (wr_y)  ybuf_q[y_cnt_q[IW-1:0]] <= in_block;
            if (wr_cb) cbuf_q  <= in_block;
            if (wr_cr) crbuf_q <= in_block;
            if (load_out) begin
                y_out_q  <= ybuf_q[IW'(k_load)];
                cb_out_q <= cb_up;
                cr_out_q <= cr_up;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign seq_err      = seq_err_q;
    assign out_idx      = k_q;
    assign y_block_out  = y_out_q;
    assign cb_block_out = cb_out_q;
    assign cr_block_out = cr_out_q;

endmodule
